// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: memory-op codes,
// FSM state codes and op classification / alignment helpers.
package mem_stage_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  function automatic logic is_load(input logic [3:0] op);
    logic r;
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    logic r;
    case (op)
      MEM_OP_SB, MEM_OP_SH, MEM_OP_SW: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return is_load(op) | is_store(op);
  endfunction

  // Word accesses need addr[1:0] == 0, halfword accesses need addr[0] == 0.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic r;
    case (op)
      MEM_OP_LW, MEM_OP_SW:              r = (lo != 2'b00);
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:  r = lo[0];
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables / replicated write data,
// load lane extraction with sign/zero extension, and the misalignment flag.
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s       = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_s       = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
  assign misaligned_o = misaligned(op_i, addr_lo_i);

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = 32'd0;
    case (op_i)
      MEM_OP_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEM_OP_SH: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      MEM_OP_SW: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = 32'd0;
      end
    endcase
  end

  always_comb begin
    load_data_o = 32'd0;
    case (op_i)
      MEM_OP_LB:  load_data_o = {{24{byte_s[7]}}, byte_s};
      MEM_OP_LBU: load_data_o = {24'd0, byte_s};
      MEM_OP_LH:  load_data_o = {{16{half_s[15]}}, half_s};
      MEM_OP_LHU: load_data_o = {16'd0, half_s};
      MEM_OP_LW:  load_data_o = rdata_i;
      default:    load_data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with a load/store unit driving a request/grant/response
// data-memory port; stalls the pipeline while an access is outstanding.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 32,
  parameter int RF_AW  = 5,
  parameter int HILO_W = 66
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [3:0]        ex_mem_op,
  input  logic              ex_rf_we,
  input  logic [RF_AW-1:0]  ex_rf_waddr,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  logic [HILO_W-1:0] ex_hilo,
  output logic              dmem_req,
  output logic              dmem_wr,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stall_req,
  output logic              wb_valid,
  output logic [PC_W-1:0]   wb_pc,
  output logic              wb_rf_we,
  output logic [RF_AW-1:0]  wb_rf_waddr,
  output logic [31:0]       wb_rf_wdata,
  output logic [HILO_W-1:0] wb_hilo,
  output logic              fwd_we,
  output logic [RF_AW-1:0]  fwd_waddr,
  output logic [31:0]       fwd_wdata,
  output logic              fwd_load_pending,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] exc_badvaddr
);

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [3:0]        op_q;
  logic              rf_we_q;
  logic [RF_AW-1:0]  waddr_q;
  logic [31:0]       result_q;
  logic [31:0]       sdata_q;
  logic [HILO_W-1:0] hilo_q;
  logic [31:0]       ldata_q, ldata_d;
  lsu_state_e        state_q, state_d;

  logic [3:0]  align_be_s;
  logic [31:0] align_wdata_s;
  logic [31:0] align_ldata_s;
  logic        align_mis_s;
  logic        cur_mem_s, cur_load_s, cur_store_s, cur_mis_s;
  logic        cap_mem_s, cap_mis_s;
  lsu_state_e  cap_next_s, pend_next_s;
  logic        req_s, complete_s, exc_s;

  lsu_align u_align (
    .op_i         (op_q),
    .addr_lo_i    (result_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (dmem_rdata),
    .be_o         (align_be_s),
    .wdata_o      (align_wdata_s),
    .load_data_o  (align_ldata_s),
    .misaligned_o (align_mis_s)
  );

  // Stage input register; a capture with ex_valid low loads a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || (!hold && !ex_valid)) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      op_q     <= MEM_OP_NONE;
      rf_we_q  <= 1'b0;
      waddr_q  <= '0;
      result_q <= 32'd0;
      sdata_q  <= 32'd0;
      hilo_q   <= '0;
    end else if (!hold) begin
      valid_q  <= 1'b1;
      pc_q     <= ex_pc;
      op_q     <= ex_mem_op;
      rf_we_q  <= ex_rf_we;
      waddr_q  <= ex_rf_waddr;
      result_q <= ex_result;
      sdata_q  <= ex_store_data;
      hilo_q   <= ex_hilo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ldata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      ldata_q <= ldata_d;
    end
  end

  // Where an op goes once it is in the register: straight to REQ, or to DONE
  // when misaligned so it never touches memory.
  assign cap_mem_s   = ex_valid & is_mem(ex_mem_op);
  assign cap_mis_s   = misaligned(ex_mem_op, ex_result[1:0]);
  assign cap_next_s  = cap_mem_s ? (cap_mis_s ? ST_DONE : ST_REQ) : ST_IDLE;
  assign cur_mem_s   = valid_q & is_mem(op_q);
  assign cur_load_s  = valid_q & is_load(op_q);
  assign cur_store_s = valid_q & is_store(op_q);
  assign cur_mis_s   = valid_q & align_mis_s;
  assign pend_next_s = cur_mem_s ? (cur_mis_s ? ST_DONE : ST_REQ) : ST_IDLE;

  always_comb begin
    state_d = state_q;
    ldata_d = ldata_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (flush)      state_d = ST_IDLE;
        else if (!hold) state_d = cap_next_s;
        else            state_d = state_q;
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          if (cur_load_s) state_d = flush ? ST_DRAIN : ST_WAIT;
          else            state_d = flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            ldata_d = align_ldata_s;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      // The orphaned response is swallowed here; an op captured meanwhile
      // starts only once it has gone by.
      ST_DRAIN: begin
        if (!dmem_rvalid) state_d = ST_DRAIN;
        else if (flush)   state_d = ST_IDLE;
        else if (!hold)   state_d = cap_next_s;
        else              state_d = pend_next_s;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_s      = (state_q == ST_REQ) & cur_mem_s;
  assign dmem_req   = req_s;
  assign dmem_wr    = req_s & cur_store_s;
  assign dmem_be    = req_s ? align_be_s : 4'b0000;
  assign dmem_addr  = req_s ? {result_q[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata = (req_s & cur_store_s) ? align_wdata_s : 32'd0;

  assign stall_req = cur_mem_s & ((state_q == ST_REQ) | (state_q == ST_WAIT) |
                                  (state_q == ST_DRAIN));

  assign complete_s  = valid_q & ((op_q == MEM_OP_NONE) | (state_q == ST_DONE));
  assign exc_s       = complete_s & cur_mis_s;
  assign wb_valid    = complete_s;
  assign wb_pc       = pc_q;
  assign wb_rf_we    = rf_we_q & complete_s & ~exc_s;
  assign wb_rf_waddr = waddr_q;
  assign wb_rf_wdata = is_load(op_q) ? ldata_q : result_q;
  assign wb_hilo     = complete_s ? hilo_q : '0;

  assign fwd_we           = wb_rf_we;
  assign fwd_waddr        = wb_rf_waddr;
  assign fwd_wdata        = wb_rf_wdata;
  assign fwd_load_pending = cur_load_s & (state_q != ST_DONE);

  assign exc_adel     = exc_s & is_load(op_q);
  assign exc_ades     = exc_s & is_store(op_q);
  assign exc_badvaddr = exc_s ? result_q[ADDR_W-1:0] : '0;

endmodule
